// File: rtl/data_memory_param_if.sv
// rtl/data_memory_param_if.sv - request/response bus between a requester and data_memory_param
interface data_memory_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                    read;
    logic                    write;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    busywait;

    modport master (
        output read, write, address, writedata, byteenable,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata, byteenable,
        output readdata, busywait
    );
endinterface

// File: rtl/data_memory_param.sv
// rtl/data_memory_param.sv - parametrised slow backing data memory with byte-enable writes and busywait handshake
module data_memory_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int LATENCY    = 5
) (
    input  logic               clock,
    input  logic               reset,
    data_memory_param_if.slave bus
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int LANES  = DATA_WIDTH / 8;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   readdata_q;
    logic [ADDR_WIDTH-1:0]   lat_address;
    logic [DATA_WIDTH-1:0]   lat_writedata;
    logic [LANES-1:0]        lat_byteenable;
    logic                    lat_write;
    logic                    valid_req;

    // A request is only meaningful when exactly one of read/write is asserted.
    assign valid_req = bus.read ^ bus.write;

    // Stall the requester from the moment a valid request appears until the access completes.
    assign bus.busywait = valid_req && (state != DONE);
    assign bus.readdata = readdata_q;

    // Request FSM: latch on accept, count down the latency, access, then one DONE cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            readdata_q     <= '0;
            lat_address    <= '0;
            lat_writedata  <= '0;
            lat_byteenable <= '0;
            lat_write      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (valid_req) begin
                        lat_address    <= bus.address;
                        lat_writedata  <= bus.writedata;
                        lat_byteenable <= bus.byteenable;
                        lat_write      <= bus.write;
                        cnt            <= CNT_W'(LATENCY - 1);
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (!valid_req) begin
                        // Requester withdrew (or went illegal): abandon without touching memory.
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (lat_write) begin
                            for (int k = 0; k < LANES; k++) begin
                                if (lat_byteenable[k]) begin
                                    mem[lat_address][8*k +: 8] <= lat_writedata[8*k +: 8];
                                end
                            end
                        end else begin
                            readdata_q <= mem[lat_address];
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_param.sv
// tb/tb_data_memory_param.sv - scoreboard bench for data_memory_param
module tb_data_memory_param;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int LAT = 5;
    localparam int BUSY_CYCLES = LAT + 1;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          busy;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    data_memory_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_memory_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: counts busy cycles of a held valid request and scores each completion.
    initial begin
        int busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clock);
            if (!reset && (bus.read ^ bus.write)) begin
                if (bus.busywait) begin
                    busy_cnt++;
                end else begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_completion: got completion expected none");
                    end else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (busy_cnt != e.busy) begin
                            errors++;
                            $display("FAIL %s_busy: got %0d cycles expected %0d", e.name, busy_cnt, e.busy);
                        end
                        if (e.is_read) check32({e.name, "_data"}, bus.readdata, e.data);
                    end
                    busy_cnt = 0;
                end
            end else begin
                busy_cnt = 0;
            end
        end
    end

    task automatic idle_bus();
        bus.read = 1'b0;
        bus.write = 1'b0;
    endtask

    // Issue one access, optionally altering address/data one cycle after acceptance.
    task automatic do_access(input string name, input bit rd, input logic [5:0] a,
                             input logic [31:0] d, input logic [3:0] be,
                             input logic [31:0] exp_data, input bit mutate);
        exp_t e;
        int n;
        bit done;
        e.is_read = rd;
        e.data = exp_data;
        e.busy = BUSY_CYCLES;
        e.name = name;
        exp_q.push_back(e);
        bus.read = rd;
        bus.write = !rd;
        bus.address = a;
        bus.writedata = d;
        bus.byteenable = be;
        if (mutate) begin
            @(posedge clock); #1;
            @(posedge clock); #1;
            bus.address = 6'd9;
            bus.writedata = 32'h0;
        end
        done = 1'b0;
        for (n = 0; n < 50 && !done; n++) begin
            @(negedge clock);
            if (!bus.busywait) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busywait stuck high expected completion", name);
            void'(exp_q.pop_back());
        end
        @(posedge clock); #1;
        idle_bus();
        @(posedge clock); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.address = '0;
        bus.writedata = '0;
        bus.byteenable = '0;
        repeat (2) @(posedge clock);
        #1;
        check32("reset_readdata", bus.readdata, 32'h0);
        check32("reset_busywait", {31'h0, bus.busywait}, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        do_access("rd_3f_after_reset", 1'b1, 6'h3F, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
        do_access("wr_5_full", 1'b0, 6'd5, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        do_access("rd_5", 1'b1, 6'd5, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        do_access("wr_2_full", 1'b0, 6'd2, 32'h11223344, 4'hF, 32'h0, 1'b0);
        do_access("wr_2_be5", 1'b0, 6'd2, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0);
        do_access("rd_2_merge", 1'b1, 6'd2, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        do_access("wr_2_be0", 1'b0, 6'd2, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        do_access("rd_2_be0", 1'b1, 6'd2, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        do_access("wr_7_latched", 1'b0, 6'd7, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1);
        do_access("rd_7_latched", 1'b1, 6'd7, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        do_access("rd_9_untouched", 1'b1, 6'd9, 32'h0, 4'h0, 32'h0, 1'b0);
        do_access("rd_5_prep", 1'b1, 6'd5, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Abort: drop a write to address 5 after two BUSY cycles.
        bus.write = 1'b1;
        bus.address = 6'd5;
        bus.writedata = 32'h12345678;
        bus.byteenable = 4'hF;
        repeat (3) @(posedge clock);
        #1;
        idle_bus();
        repeat (2) @(posedge clock);
        #1;
        check32("abort_readdata_held", bus.readdata, 32'hDEADBEEF);
        do_access("rd_5_after_abort", 1'b1, 6'd5, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Illegal read+write held for 10 cycles: never stalls, never accesses.
        bus.read = 1'b1;
        bus.write = 1'b1;
        bus.address = 6'd2;
        bus.writedata = 32'h0;
        bus.byteenable = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check32("illegal_busywait", {31'h0, bus.busywait}, 32'h0);
        end
        @(posedge clock); #1;
        idle_bus();
        check32("illegal_readdata_held", bus.readdata, 32'hDEADBEEF);
        @(posedge clock); #1;
        do_access("rd_2_after_illegal", 1'b1, 6'd2, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

        // Asynchronous reset two cycles after a write to address 1 is accepted.
        bus.write = 1'b1;
        bus.address = 6'd1;
        bus.writedata = 32'hFFFFFFFF;
        bus.byteenable = 4'hF;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        idle_bus();
        #1;
        check32("midreset_readdata", bus.readdata, 32'h0);
        check32("midreset_busywait", {31'h0, bus.busywait}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        do_access("rd_1_after_reset", 1'b1, 6'd1, 32'h0, 4'h0, 32'h0, 1'b0);
        do_access("rd_5_cleared", 1'b1, 6'd5, 32'h0, 4'h0, 32'h0, 1'b0);

        repeat (2) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
